// File: rtl/fetch_router.sv
// fetch_router
//   Routes CPU instruction fetches to one of REGIONS instruction memories.
//   It decodes each fetch against inclusive per-region byte bounds and
//   forwards the fetch in the same cycle, with a region-relative word address.
//   Responses pass straight through from the active region's done strobe.
//   Traffic is kept to a single region at a time, so responses come back in
//   program order without a reorder buffer.
//   After an invalidate, responses still in flight are counted and then dropped.
//   Fetches to unmapped addresses are answered locally one cycle later.
//
//   Build option: define FETCH_ROUTER_ERROR_EN to report unmapped fetches as
//   bus errors (error_o=1, instruction 0). When it is undefined, an unmapped
//   fetch returns a NOP (32'h13) and error_o is tied low.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   fetch_i, address_i     CPU fetch request / word-aligned byte address
//   invalidate_i           flush every in-flight fetch
//   stall_o                request not accepted this cycle
//   valid_o, instruction_o response strobe and data (data 0 when not valid)
//   error_o                response is a bus error
//   slave_fetch_o          per-region fetch strobe
//   slave_address_o        per-region word address, region r at [r*32 +: 32]
//   slave_invalidate_o     invalidate broadcast to all regions
//   slave_instruction_i    per-region read data, region r at [r*32 +: 32]
//   slave_done_i           per-region in-order response strobe

module fetch_router #(
    parameter int          REGIONS                     = 2,
    parameter int          OUTSTANDING                 = 4,
    parameter logic [31:0] LOW_ADDRESS  [REGIONS]      = '{32'h0000_0000, 32'h0000_1000},
    parameter logic [31:0] HIGH_ADDRESS [REGIONS]      = '{32'h0000_07FF, 32'h0000_4FFF}
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    fetch_i,
    input  logic [31:0]             address_i,
    input  logic                    invalidate_i,
    output logic                    stall_o,
    output logic                    valid_o,
    output logic [31:0]             instruction_o,
    output logic                    error_o,
    output logic [REGIONS-1:0]      slave_fetch_o,
    output logic [REGIONS*32-1:0]   slave_address_o,
    output logic [REGIONS-1:0]      slave_invalidate_o,
    input  logic [REGIONS*32-1:0]   slave_instruction_i,
    input  logic [REGIONS-1:0]      slave_done_i
);

    localparam int AW = (REGIONS > 1) ? $clog2(REGIONS) : 1;
    localparam int CW = $clog2(OUTSTANDING) + 1;

`ifdef FETCH_ROUTER_ERROR_EN
    localparam logic [31:0] UNMAPPED_INSN = 32'h0000_0000;
`else
    localparam logic [31:0] UNMAPPED_INSN = 32'h0000_0013;
`endif

    // ---------------------------------------------------------------- decode
    logic [32:0]        lo_diff [REGIONS];
    logic [REGIONS-1:0] hit_vec;
    logic [REGIONS-1:0] sel_vec;
    logic               hit_any;
    logic [AW-1:0]      hit_idx;

    for (genvar g = 0; g < REGIONS; g++) begin : g_region
        // The borrow out of a 33-bit subtract gives the lower-bound test. The
        // low 32 bits of the same subtract are the region-relative offset.
        assign lo_diff[g] = {1'b0, address_i} - {1'b0, LOW_ADDRESS[g]};
        assign hit_vec[g] = !lo_diff[g][32] && (address_i <= HIGH_ADDRESS[g]);
        assign slave_address_o[g*32 +: 32] = lo_diff[g][31:0] >> 2;
    end

    assign hit_any = |hit_vec;
    // If regions overlap, the lowest index wins: keep only the lowest set bit.
    assign sel_vec = hit_vec & ~(hit_vec - REGIONS'(1));

    always_comb begin
        hit_idx = '0;
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = AW'(i);
        end
    end

    // ----------------------------------------------------------------- state
    logic [AW-1:0] active_q,   active_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q,  discard_d;
    logic          err_q,      err_d;

    logic [CW-1:0] pending;
    logic          busy, full, accept, accept_map;
    logic          done, drop, take;

    assign pending = inflight_q + discard_q;
    assign busy    = (pending != '0);
    assign full    = (pending == CW'(OUTSTANDING));

    // While anything is still owed by the active region, only that region may
    // take new requests. This is what keeps responses in order.
    assign stall_o = invalidate_i | err_q | full |
                     (busy & (!hit_any | (hit_idx != active_q)));

    assign accept     = fetch_i & ~stall_o;
    assign accept_map = accept & hit_any;

    assign slave_fetch_o      = accept_map ? sel_vec : '0;
    assign slave_invalidate_o = {REGIONS{invalidate_i}};

    // Done strobes from regions other than the active one are ignored. The
    // inflight guard protects the counter from a spurious strobe.
    assign done = slave_done_i[active_q];
    assign drop = done & (discard_q != '0);
    assign take = done & (discard_q == '0) & (inflight_q != '0);

    always_comb begin
        active_d   = accept_map ? hit_idx : active_q;
        err_d      = accept & ~hit_any;
        inflight_d = inflight_q + CW'(accept_map) - CW'(take);
        discard_d  = discard_q - CW'(drop);
        if (invalidate_i) begin
            // Everything still owed becomes a discard, less this cycle's done.
            inflight_d = '0;
            discard_d  = pending - CW'(drop | take);
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q   <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            active_q   <= active_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            err_q      <= err_d;
        end
    end

    // -------------------------------------------------------------- response
    always_comb begin
        valid_o       = 1'b0;
        instruction_o = '0;
        if (!invalidate_i) begin
            if (take) begin
                valid_o       = 1'b1;
                instruction_o = slave_instruction_i[active_q*32 +: 32];
            end else if (err_q) begin
                valid_o       = 1'b1;
                instruction_o = UNMAPPED_INSN;
            end
        end
    end

`ifdef FETCH_ROUTER_ERROR_EN
    assign error_o = err_q & ~invalidate_i;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: doc/fetch_router.md
# fetch_router

Parametrised instruction-fetch router between the CPU fetch channel and `REGIONS` instruction-capable memories (boot memory, system memory, additional banks). It decodes each fetch address against per-region bounds, translates it to a region-relative word address, and tracks in-flight fetches so responses return in program order. It also discards stale responses after an invalidate and answers fetches to unmapped addresses itself. It replaces hard-wired two-memory fetch decode in the SoC top level.

## Interface
- `REGIONS`, 2, number of fetch targets (1..8)
- `OUTSTANDING`, 4, maximum in-flight fetches, including discards (power of two, ≥2)
- `LOW_ADDRESS[REGIONS]`, `'{0, 32'h1000}`, inclusive region base byte addresses
- `HIGH_ADDRESS[REGIONS]`, `'{32'h7FF, 32'h4FFF}`, inclusive region end byte addresses

Ports:
- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `fetch_i` in 1: fetch request.
- `address_i` in 32: fetch byte address (word aligned).
- `invalidate_i` in 1: flush all in-flight fetches.
- `stall_o` out 1: request not accepted this cycle.
- `valid_o` out 1: response valid.
- `instruction_o` out 32: response instruction.
- `error_o` out 1: response is a bus error (qualified by `valid_o`).
- `slave_fetch_o` out REGIONS: per-region fetch strobe.
- `slave_address_o` out REGIONS×32: `(address_i - LOW_ADDRESS[i]) >> 2`.
- `slave_invalidate_o` out REGIONS: `invalidate_i` broadcast to every region.
- `slave_instruction_i` in REGIONS×32: region read data.
- `slave_done_i` in REGIONS: region response strobe. Each region responds in order, ≥1 cycle after its request.

## Operation
- Decode (combinational): region i hits when `LOW_ADDRESS[i] <= address_i <= HIGH_ADDRESS[i]`. On overlap, the lowest index wins. No hit means unmapped.
- Accept = `fetch_i & !stall_o`. `slave_fetch_o[i]` = accept & hit[i]. The request is forwarded in the same cycle with no added latency.
- State:
  - `active` region register.
  - `inflight` counter (0..OUTSTANDING): requests whose response is still expected and will be delivered.
  - `discard` counter: responses still expected but to be dropped. Invariant: `inflight + discard <= OUTSTANDING`.
  - `err_pending` flag.
- On a mapped accept, `active` ← hit index and `inflight` increments.
- `stall_o` = `invalidate_i` | `err_pending` | (`inflight+discard == OUTSTANDING`) | (`inflight+discard != 0` & (hit index != `active` | unmapped)).
  - Consequence: only one region has traffic at a time, which guarantees ordering.
- Response: when `slave_done_i[active]` is high:
  - If `discard != 0`: `discard` decrements and `valid_o` stays 0.
  - Otherwise: `valid_o`=1, `instruction_o`=`slave_instruction_i[active]`, and `inflight` decrements.
  - `slave_done_i` from a non-active region is ignored.
- Simultaneous accept and delivered done: `inflight` is unchanged.
- Invalidate:
  - `discard` ← `discard + inflight` − (1 if a done arrives that cycle).
  - `inflight` ← 0.
  - `err_pending` is cleared.
  - `valid_o` is forced 0 that cycle.
  - No accept occurs that cycle, since `stall_o` is high.
- Unmapped accept (only possible when idle): `err_pending` set. The next cycle produces the error response (see Configuration) and clears the flag.
- `instruction_o` = 0 whenever `valid_o`=0.

## Timing
- Reset (async, while `rst_i`=1): counters 0, `active`=0, `err_pending`=0.
  - `valid_o`=0, `error_o`=0, `instruction_o`=0.
  - `stall_o`=0 unless `invalidate_i`=1.
  - `slave_fetch_o`=0 unless `fetch_i`.
  - Reset mid-operation abandons all tracking. Slaves receive no invalidate from this block on reset.
- Mapped fetch: request forwarded at cycle T. The response appears in the same cycle as the slave's `slave_done_i` (combinational pass-through).
- Unmapped fetch: accepted at T, response at T+1.
- Region switch: the first request to a new region is accepted in the cycle after the last outstanding or discarded done of the previous region.

## Configuration
- `FETCH_ROUTER_ERROR_EN` defined: an unmapped response drives `valid_o`=1, `error_o`=1, `instruction_o`=0.
- `FETCH_ROUTER_ERROR_EN` undefined: an unmapped response drives `valid_o`=1, `error_o`=0, `instruction_o`=32'h0000_0013 (NOP). In this case `error_o` is tied 0.

## Test plan
- Assert `rst_i` with `fetch_i`=0 → `valid_o`=0, `error_o`=0, `stall_o`=0. A subsequent fetch to 0x0 is accepted in the first cycle after release.
- Fetch 0x1008 → `slave_fetch_o`=2'b10, `slave_address_o[1]`=0x2. Region 1 done with 0xDEADBEEF → same-cycle `valid_o`=1, `instruction_o`=0xDEADBEEF.
- Four back-to-back fetches to region 0 with no done → fifth fetch sees `stall_o`=1. One done → fifth accepted the next cycle. Four in-order responses follow.
- Two outstanding in region 0, fetch 0x1000 → stalled until the second region-0 done. Accepted the following cycle.
- Three in-flight, pulse `invalidate_i` → next three dones give `valid_o`=0. A new fetch to the same region accepted during discard returns `valid_o`=1 with its own data.
- Fetch 0x9000_0000 → next cycle `valid_o`=1 with `error_o`=1/`instruction_o`=0 (macro defined), or `error_o`=0/`instruction_o`=0x13 (macro undefined). No `slave_fetch_o`.
